// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared definitions for the round-robin arbitration blocks: FSM state
// encodings, the default hold limit and pointer arithmetic.
package rr_encoder_arbiter_pkg;

  // Two-state arbitration FSM shared by the team's arbiters.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Default number of consecutive cycles one grant may be held.
  localparam int RR_MAX_HOLD_DEFAULT = 8;

  // Advance the rotating priority pointer past the given requester.
  // Two-bit arithmetic gives the wrap 3 -> 0 for free.
  function automatic logic [1:0] next_ptr(input logic [1:0] id);
    return id + 2'd1;
  endfunction

endpackage : rr_encoder_arbiter_pkg

// File: rtl/rr_onehot_enc.sv
// One-hot to binary index encoder (4 in, 2 out). A zero or illegal
// multi-hot input encodes to index 0.
module rr_onehot_enc (
  input  logic [3:0] onehot_i,
  output logic [1:0] index_o
);

  // Map each legal one-hot code to its bit position.
  always_comb begin
    index_o = 2'd0;
    case (onehot_i)
      4'b0001: index_o = 2'd0;
      4'b0010: index_o = 2'd1;
      4'b0100: index_o = 2'd2;
      4'b1000: index_o = 2'd3;
      default: index_o = 2'd0;
    endcase
  end

endmodule : rr_onehot_enc

// File: rtl/rr_encoder_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A winner is picked in IDLE starting from the rotating pointer, held in
// GRANT until it releases or hits MAX_HOLD, and every grant is followed by
// at least one IDLE turnaround cycle. All outputs are registered.
module rr_encoder_arbiter
  import rr_encoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = RR_MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  arb_state_e state_q;
  logic [1:0] ptr_q;
  logic [3:0] hold_cnt_q;
  logic [3:0] grant_q;
  logic [1:0] grant_id_q;
  logic       busy_q;
  logic       timeout_q;

  logic [3:0] cand_grant_d;
  logic [1:0] cand_id_d;
  logic       found_s;
  logic       hit_s;

  // Rotating priority scan: first set request at ptr, ptr+1, ptr+2, ptr+3.
  always_comb begin
    cand_grant_d = 4'b0000;
    found_s      = 1'b0;
    hit_s        = 1'b0;
    for (int off = 0; off < 4; off++) begin
      hit_s = ~found_s & req[2'(ptr_q + 2'(off))];
      cand_grant_d[2'(ptr_q + 2'(off))] = hit_s;
      found_s = found_s | hit_s;
    end
  end

  rr_onehot_enc u_enc (
    .onehot_i (cand_grant_d),
    .index_o  (cand_id_d)
  );

  // Arbitration FSM with registered grant, index, busy and timeout outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 4'd0;
      grant_q    <= 4'b0000;
      grant_id_q <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found_s) begin
            grant_q    <= cand_grant_d;
            grant_id_q <= cand_id_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= 4'd1;
            state_q    <= ST_GRANT;
          end else begin
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            hold_cnt_q <= 4'd0;
            state_q    <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (!req[grant_id_q]) begin
            // Voluntary release takes precedence over the hold limit.
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            hold_cnt_q <= 4'd0;
            ptr_q      <= next_ptr(grant_id_q);
            state_q    <= ST_IDLE;
          end else if (hold_cnt_q == HOLD_LIMIT) begin
            // Forced revoke: flag it in the first IDLE cycle.
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            hold_cnt_q <= 4'd0;
            ptr_q      <= next_ptr(grant_id_q);
            timeout_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
            state_q    <= ST_GRANT;
          end
        end
        default: begin
          grant_q    <= 4'b0000;
          grant_id_q <= 2'd0;
          busy_q     <= 1'b0;
          hold_cnt_q <= 4'd0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule : rr_encoder_arbiter

// File: tb/tb_rr_encoder_arbiter.sv
// Scoreboard bench for rr_encoder_arbiter: a driver issues one request
// vector per cycle and pushes the reference model's expected outputs; a
// monitor pops and compares on every falling edge and also checks the
// structural output invariants.
module tb_rr_encoder_arbiter;

  localparam int MAXH = 8;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  rr_encoder_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       t;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource, for how many cycles, and
  // which requester has top priority next time.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_tout  = 0;
  int n_tout  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_tout  = 0;
  endtask

  // Advance the model by one clock edge with request vector r.
  task automatic model_step(input logic [3:0] r, output exp_t e);
    m_tout = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          m_held  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_held  = 0;
    end else if (m_held == MAXH) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_held  = 0;
      m_tout  = 1;
      n_tout++;
    end else begin
      m_held++;
    end
    e.g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.b  = (m_owner >= 0);
    e.t  = (m_tout != 0);
  endtask

  task automatic step(input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    #1;
    req = r;
    model_step(r, e);
    exp_q.push_back(e);
  endtask

  // Mid-cycle reset pulse, then issue r for the next edge.
  task automatic reset_pulse_step(input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    #1;
    reset = 1'b0;
    model_reset();
    req = r;
    model_step(r, e);
    exp_q.push_back(e);
  endtask

  // Monitor: compare against the scoreboard and check output invariants.
  initial begin
    exp_t e;
    logic [1:0] id_from_grant;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("busy", 32'(busy), 32'(e.b));
        chk("timeout", 32'(timeout), 32'(e.t));
      end
      chk("onehot_or_zero", 32'($countones(grant) <= 1), 32'h1);
      chk("busy_vs_grant", 32'(busy), 32'(grant != 4'b0000));
      id_from_grant = 2'd0;
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) id_from_grant = 2'(i);
      end
      chk("id_vs_grant", 32'(grant_id), 32'(id_from_grant));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    reset = 1'b1;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("por_grant", 32'(grant), 32'h0);
    chk("por_busy", 32'(busy), 32'h0);
    chk("por_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Idle with no requests.
    repeat (3) step(4'b0000);

    // 0101 held, requester 0 wins, then releases; requester 2 follows.
    repeat (3) step(4'b0101);
    repeat (4) step(4'b0100);
    repeat (2) step(4'b0000);

    // All requesting, each winner releases after two cycles.
    reset_pulse_step(4'b0000);
    for (int n = 0; n < 16; n++) begin
      r = 4'hF;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      step(r);
    end
    repeat (2) step(4'b0000);

    // Requester 1 held forever: hold limit, timeout, re-grant.
    repeat (22) step(4'b0010);
    repeat (2) step(4'b0000);
    chk("timeouts_seen", 32'(n_tout), 32'h2);

    // Release exactly when the hold count reaches the limit: no timeout.
    repeat (MAXH) step(4'b0010);
    step(4'b0000);
    step(4'b0000);
    chk("no_extra_timeout", 32'(n_tout), 32'h2);

    // Reset during a grant of requester 2 with ptr at 2.
    reset_pulse_step(4'b0000);
    step(4'b0010);
    step(4'b0000);
    repeat (3) step(4'b0100);
    reset_pulse_step(4'b0100);
    repeat (3) step(4'b0100);
    step(4'b0000);

    // Randomized traffic with sticky requests and occasional resets.
    r = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 79) == 0) begin
        reset_pulse_step(r);
      end else begin
        step(r);
      end
    end

    @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_encoder_arbiter

// File: doc/rr_encoder_arbiter.md
RR_ENCODER_ARBITER -- requirements
Module: rr_encoder_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant is held (legal range 1..15).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port req  input  4  SHALL carry the request lines; bit i is requester i.
REQ-005 Port grant  output  4  SHALL be a one-hot registered grant, or all-zero when nothing is granted.
REQ-006 Port grant_id  output  2  SHALL hold the encoded index of the granted requester; 0 when nothing is granted.
REQ-007 Port busy  output  1  SHALL be 1 exactly when grant is non-zero.
REQ-008 Port timeout  output  1  SHALL pulse for one cycle when a grant is forcibly revoked by the hold limit.

Function
REQ-009 The block SHALL implement two states: IDLE and GRANT.
REQ-010 The block SHALL keep a 2-bit rotating priority pointer ptr and a 4-bit hold counter hold_cnt.
REQ-011 In IDLE with req non-zero, the block SHALL select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), register grant/grant_id, and enter GRANT at the next edge.
REQ-012 Grant latency SHALL be exactly 1 cycle: req sampled high at edge k gives grant visible after edge k.
REQ-013 In IDLE with req all-zero, the block SHALL stay in IDLE with all outputs 0.
REQ-014 In GRANT, hold_cnt SHALL increment every cycle, starting at 1 in the first granted cycle.
REQ-015 In GRANT, when req[grant_id] is sampled 0, the block SHALL clear grant, set ptr to grant_id+1 (mod 4), and return to IDLE.
REQ-016 In GRANT, when hold_cnt equals MAX_HOLD and req[grant_id] is still 1, the block SHALL clear grant, set ptr to grant_id+1, pulse timeout in the following cycle, and return to IDLE.
REQ-017 If req[grant_id] drops in the same cycle that hold_cnt reaches MAX_HOLD, the block SHALL treat it as a normal release with no timeout pulse.
REQ-018 Every grant SHALL be followed by at least one IDLE cycle (turnaround); back-to-back grants SHALL NOT occur.
REQ-019 Requests from non-granted requesters during GRANT SHALL be ignored until the next IDLE evaluation; they SHALL NOT be latched.
REQ-020 grant SHALL never have more than one bit set.
REQ-021 ptr arithmetic SHALL wrap modulo 4 (3+1 -> 0).

Reset
REQ-022 Asserting reset SHALL immediately force grant=0, grant_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE, regardless of clk.
REQ-023 Reset asserted mid-grant SHALL abort the grant with no timeout pulse and no ptr advance.
REQ-024 After reset deasserts, the first arbitration SHALL use ptr=0 (requester 0 highest).

Structure
REQ-025 State encodings and the MAX_HOLD default SHALL live in a shared package/include shared with the team's other arbitration blocks.
REQ-026 The one-hot-to-index conversion SHALL be a separate combinational sub-module named rr_onehot_enc (4 in, 2 out); everything else SHALL be in one module.

Verification
REQ-027 Reset, then req=4'b0101 held -> grant=0001/grant_id=0 after one edge; release of req[0] -> IDLE, ptr=1; next grant=0100/grant_id=2.
REQ-028 req=4'b1111 held, each winner releases after 2 cycles -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-029 MAX_HOLD=8, req=4'b0010 held forever -> grant=0010 for exactly 8 cycles, then timeout=1 for one cycle, then re-grant of 1 after the IDLE cycle.
REQ-030 req[1] drops in the same cycle hold_cnt=8 -> release, timeout stays 0.
REQ-031 reset pulsed during grant of requester 2 (ptr=2) -> outputs 0 asynchronously; after release with req=4'b0100, grant goes to 2 with ptr restarting at 0.
REQ-032 Every cycle, the bench SHALL check that grant is one-hot or zero, that busy equals |grant, and that grant_id matches grant.
